// File: rtl/muldiv_seq.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// sign fix-up after the loop, and single-cycle early-out for divide-by-zero and signed overflow.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] op_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] acc, mq, opnd;
  logic             neg_a, neg_b;

  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sum, rem_sh;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo_v, rem_v, fix_val;
  logic             is_div0, is_ovf, early;
  logic [WIDTH-1:0] early_val;

  always_comb begin
    sgn_a = (op_r inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110}) && a_r[WIDTH-1];
    sgn_b = (op_r inside {3'b000, 3'b001, 3'b100, 3'b110}) && b_r[WIDTH-1];
    mag_a = sgn_a ? -a_r : a_r;
    mag_b = sgn_b ? -b_r : b_r;

    // acc holds the running high half (multiply) or partial remainder (divide);
    // mq holds multiplier bits shifting out / quotient bits shifting in.
    sum    = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    rem_sh = {acc, mq[WIDTH-1]};
    ge     = rem_sh >= {1'b0, opnd};
    // When ge holds the true difference is below the divisor, so the low bits suffice.
    diff   = rem_sh[WIDTH-1:0] - opnd;

    prod = {acc, mq};
    if (neg_a ^ neg_b) prod = -prod;
    quo_v = (neg_a ^ neg_b) ? -mq : mq;
    rem_v = neg_a ? -acc : acc;

    if (op_r[2])            fix_val = op_r[1] ? rem_v : quo_v;
    else if (op_r[1:0] == 2'b00) fix_val = prod[WIDTH-1:0];
    else                    fix_val = prod[2*WIDTH-1:WIDTH];

    is_div0   = op[2] && (b == '0);
    is_ovf    = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
    early     = is_div0 || is_ovf;
    early_val = is_div0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      op_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_r     <= op;
          a_r      <= a;
          b_r      <= b;
          op_count <= op_count + 1'b1;
          busy     <= 1'b1;
          if (early) begin
            result <= early_val;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            state  <= S_PREP;
          end
        end
        S_PREP: begin
          neg_a <= sgn_a;
          neg_b <= sgn_b;
          acc   <= '0;
          mq    <= op_r[2] ? mag_a : mag_b;
          opnd  <= op_r[2] ? mag_b : mag_a;
          cnt   <= CNT_INIT;
          state <= S_ITER;
        end
        S_ITER: begin
          if (op_r[2]) begin
            acc <= ge ? diff : rem_sh[WIDTH-1:0];
            mq  <= {mq[WIDTH-2:0], ge};
          end else begin
            acc <= sum[WIDTH:1];
            mq  <= {sum[0], mq[WIDTH-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_val;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: if (!stall) begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: WIDTH=32 vector table plus corner sequences, and a WIDTH=8
// instance exercised with random ops against a behavioural reference.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;

  logic        s32, st32, busy32, done32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32, cnt32;

  logic        s8, st8, busy8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;
  logic [15:0] cnt8;

  int          n_checks, n_err;
  int          cnt_m[2];
  logic [31:0] sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t tbl[16];

  muldiv_seq #(.WIDTH(32), .CNT_W(32)) u_dut32 (
    .Clk(clk), .Reset_n(rst_n), .start(s32), .op(op32), .a(a32), .b(b32),
    .stall(st32), .busy(busy32), .done(done32), .result(res32), .op_count(cnt32)
  );

  muldiv_seq #(.WIDTH(8), .CNT_W(16)) u_dut8 (
    .Clk(clk), .Reset_n(rst_n), .start(s8), .op(op8), .a(a8), .b(b8),
    .stall(st8), .busy(busy8), .done(done8), .result(res8), .op_count(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_done(int sel);
    return (sel != 0) ? done8 : done32;
  endfunction
  function automatic logic get_busy(int sel);
    return (sel != 0) ? busy8 : busy32;
  endfunction
  function automatic logic [63:0] get_res(int sel);
    return (sel != 0) ? {56'b0, res8} : {32'b0, res32};
  endfunction
  function automatic logic [63:0] get_cnt(int sel);
    return (sel != 0) ? {48'b0, cnt8} : {32'b0, cnt32};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref8(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    int          as_, bs_, au, bu, p;
    logic [31:0] pv;
    logic [7:0]  r;
    as_ = int'($signed(a));
    bs_ = int'($signed(b));
    au  = int'({24'b0, a});
    bu  = int'({24'b0, b});
    r   = 8'h00;
    case (op)
      3'd0: begin p = as_ * bs_; pv = p; r = pv[7:0];  end
      3'd1: begin p = as_ * bs_; pv = p; r = pv[15:8]; end
      3'd2: begin p = as_ * bu;  pv = p; r = pv[15:8]; end
      3'd3: begin p = au * bu;   pv = p; r = pv[15:8]; end
      3'd4: if (b == 8'h00) r = 8'hFF;
            else if (a == 8'h80 && b == 8'hFF) r = 8'h80;
            else begin p = as_ / bs_; pv = p; r = pv[7:0]; end
      3'd5: if (b == 8'h00) r = 8'hFF;
            else begin p = au / bu; pv = p; r = pv[7:0]; end
      3'd6: if (b == 8'h00) r = a;
            else if (a == 8'h80 && b == 8'hFF) r = 8'h00;
            else begin p = as_ % bs_; pv = p; r = pv[7:0]; end
      default: if (b == 8'h00) r = a;
            else begin p = au % bu; pv = p; r = pv[7:0]; end
    endcase
    return r;
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'h01;
      4: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  // Drive one op, scramble inputs after acceptance, then wait for done and score it.
  task automatic run_op(input string nm, input int sel, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int cyc;
    @(negedge clk);
    if (sel != 0) begin s8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else begin s32 = 1'b1; op32 = op; a32 = a; b32 = b; end
    sb.push_back(exp);
    @(posedge clk); #1;
    cnt_m[sel]++;
    if (sel != 0) begin s8 = 1'b0; op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); end
    else begin s32 = 1'b0; op32 = 3'($urandom); a32 = $urandom; b32 = $urandom; end
    cyc = 1;
    while (!get_done(sel) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'(exp_lat));
    if (get_done(sel)) chk({nm, " result"}, get_res(sel), {32'b0, sb.pop_front()});
    else void'(sb.pop_front());
    chk({nm, " op_count"}, get_cnt(sel), 64'(cnt_m[sel]));
    @(posedge clk); #1;
    chk({nm, " done_one_cycle"}, {62'b0, get_done(sel), get_busy(sel)}, 64'd0);
  endtask

  initial begin
    int   cyc;
    logic [31:0] r0;
    logic [2:0]  rop;
    logic [7:0]  ra, rb;
    logic        rearly;

    n_checks = 0; n_err = 0; cnt_m[0] = 0; cnt_m[1] = 0;
    rst_n = 1'b0;
    s32 = 1'b0; st32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    s8  = 1'b0; st8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;

    tbl[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 35};
    tbl[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35};
    tbl[2]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 35};
    tbl[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 35};
    tbl[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35};
    tbl[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35};
    tbl[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       35};
    tbl[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        35};
    tbl[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    tbl[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        1};
    tbl[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    tbl[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    tbl[12] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 35};
    tbl[13] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        35};
    tbl[14] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        35};
    tbl[15] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        35};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy32", {63'b0, busy32}, 64'd0);
    chk("reset done32", {63'b0, done32}, 64'd0);
    chk("reset result32", {32'b0, res32}, 64'd0);
    chk("reset op_count32", {32'b0, cnt32}, 64'd0);
    chk("reset result8", {56'b0, res8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), 0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

    // Stall on DONE for 3 cycles while start is held high throughout the busy period.
    @(negedge clk);
    st32 = 1'b1; s32 = 1'b1; op32 = 3'd5; a32 = 32'd100; b32 = 32'd7;
    sb.push_back(32'd14);
    @(posedge clk); #1;
    cnt_m[0]++;
    a32 = $urandom; b32 = $urandom;
    cyc = 1;
    while (!done32 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("stall latency", 64'(cyc), 64'd35);
    chk("stall result", {32'b0, res32}, {32'b0, sb.pop_front()});
    r0 = res32;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall hold done%0d", k), {63'b0, done32}, 64'd1);
      chk($sformatf("stall hold result%0d", k), {32'b0, res32}, {32'b0, r0});
    end
    st32 = 1'b0; s32 = 1'b0;
    @(posedge clk); #1;
    chk("stall release done", {63'b0, done32}, 64'd0);
    chk("stall op_count", {32'b0, cnt32}, 64'(cnt_m[0]));

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    s32 = 1'b1; op32 = 3'd4; a32 = 32'd1000; b32 = 32'd3;
    @(posedge clk); #1;
    s32 = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cnt_m[0] = 0; cnt_m[1] = 0;
    chk("midreset busy", {63'b0, busy32}, 64'd0);
    chk("midreset done", {63'b0, done32}, 64'd0);
    chk("midreset result", {32'b0, res32}, 64'd0);
    chk("midreset op_count", {32'b0, cnt32}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset_mul", 0, 3'd0, 32'd3, 32'd4, 32'd12, 35);

    // WIDTH=8 instance.
    run_op("w8_div_ovf", 1, 3'd4, 32'h80, 32'hFF, 32'h80, 1);
    run_op("w8_mulh", 1, 3'd1, 32'h80, 32'h7F, 32'hC0, 11);
    for (int i = 0; i < 1000; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = pick8();
      rb = pick8();
      rearly = rop[2] && (rb == 8'h00 || (!rop[0] && ra == 8'h80 && rb == 8'hFF));
      run_op($sformatf("w8_rand%0d_op%0d_%02h_%02h", i, rop, ra, rb), 1, rop,
             {24'b0, ra}, {24'b0, rb}, {24'b0, ref8(rop, ra, rb)}, rearly ? 1 : 11);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
